pattern_scan_ctrl: RTL and testbench
====================================

// Module: pattern_scan_ctrl
// PURPOSE
//  Word-level controller that sequences a serial Mealy pattern detector.
//  Accepts WIDTH-bit words on a valid/ready handshake and shifts them MSB-first, one bit per Clk.
//  Detects PATTERN with overlap and counts matches per word.
//  Returns the count on a second valid/ready handshake.
// PARAMETERS
//  WIDTH    8        bits per input word; legal range >= PLEN
//  PLEN     4        pattern length; legal range 2..WIDTH
//  PATTERN  4'b0110  target sequence; MSB is the first bit received
//  CNT_W    $clog2(WIDTH+1)  localparam; width of the match counter
// PORTS
//  Clk        in   1      clock; all state changes on the rising edge
//  Rst        in   1      asynchronous reset, active-low (Rst=0 resets)
//  in_valid   in   1      input word available
//  in_ready   out  1      controller can accept a word (IDLE only)
//  in_data    in   WIDTH  word to scan
//  out_valid  out  1      out_count is valid
//  out_ready  in   1      consumer takes the result
//  out_count  out  CNT_W  matches found in the last word
//  match      out  1      Mealy output: current bit completes PATTERN (SHIFT only)
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (async on Rst=0):
//   - state=IDLE, in_ready=1, out_valid=0, out_count=0, match=0, busy=0.
//   - History register and fill counter cleared.
//   - Reset mid-SHIFT or mid-REPORT abandons the word and produces no result.
//  FSM states: IDLE, SHIFT, REPORT.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready: latch in_data, bit_idx=WIDTH-1, cnt=0, go to SHIFT.
//  SHIFT (exactly WIDTH cycles):
//   - cur=word[bit_idx].
//   - match = (fill>=PLEN-1) && ({hist[PLEN-2:0],cur}==PATTERN); combinational, Mealy.
//   - Each edge: hist<={hist,cur}, fill saturates at PLEN-1, cnt+=match, bit_idx--.
//   - At the edge where bit_idx==0, go to REPORT.
//  REPORT:
//   - out_valid=1; out_count=cnt, held stable while out_ready=0.
//   - On out_ready, go to IDLE; out_valid drops on the next cycle.
//  Latency and throughput:
//   - out_valid rises WIDTH edges after the input handshake edge.
//   - Minimum spacing between input handshakes is WIDTH+2 cycles.
//  Other rules:
//   - in_ready=0 in SHIFT and REPORT; in_valid is ignored there.
//   - Overlapping matches are all counted (0110110 -> 2).
//   - out_count cannot overflow: CNT_W covers WIDTH matches.
//   - match=0 outside SHIFT.
// CONFIGURATION
//  PSC_CARRY_STATE_EN
//   - Defined: hist and fill persist across words; only reset clears them.
//     A match spanning a word boundary counts in the word holding its final bit.
//   - Undefined (default): hist and fill clear on each input handshake.
//     Matches are confined to a single word.
// TESTING (WIDTH=8, PLEN=4, PATTERN=4'b0110)
//  1. Word 8'b0110_0110, out_ready=1 -> match pulses on scan bits 4 and 8; out_count=2;
//     out_valid 8 edges after accept.
//  2. Overlap: word 8'b0110_1100 -> out_count=2 (windows 0-3 and 3-6); 8'hFF -> 0; 8'h00 -> 0.
//  3. Backpressure: out_ready=0 for 5 cycles in REPORT -> out_valid=1 and out_count stable;
//     in_ready=0; a held in_valid is not accepted until after the out handshake.
//  4. Boundary: words 8'b0000_0011 then 8'b0100_0000 -> counts 0,0 without PSC_CARRY_STATE_EN;
//     0,1 with it.
//  5. Reset mid-SHIFT after 3 bits of 8'b0110_0110 -> all outputs take reset values at once.
//     No out_valid follows; the next word 8'b0110_0000 gives out_count=1.
//  6. Back-to-back: in_valid held high with out_ready=1 -> second word accepted in the IDLE
//     cycle after REPORT; handshakes spaced 10 cycles apart.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Word-level controller around a serial Mealy pattern detector. A WIDTH-bit
//   word is taken on an in_valid/in_ready handshake. It is then shifted MSB-first,
//   one bit per clock, through a PLEN-deep history window. Every window equal to
//   PATTERN is counted, and overlapping windows are counted too. The per-word match
//   count is returned on an out_valid/out_ready handshake.
//
//   Build option PSC_CARRY_STATE_EN:
//     defined   - history and fill level persist across words, so a match may
//                 span a word boundary. It is counted in the word that holds its
//                 final bit. Only reset clears the history.
//     undefined - history and fill level clear on every accepted word.
module pattern_scan_ctrl #(
  parameter int              WIDTH   = 8,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b0110,
  localparam int             CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             match,
  output logic             busy
);

  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FILL_W = $clog2(PLEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_word;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [PLEN-2:0]    r_hist;
  logic [FILL_W-1:0]  r_fill;

  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic               w_cur;
  logic [PLEN-1:0]    w_window;
  logic               w_fill_ok;
  logic               w_accept;
  logic               w_match;

  // The bit under scan, and the candidate window formed by appending it to the history.
  assign w_cur     = r_word[r_bit_idx];
  assign w_window  = {r_hist, w_cur};
  // The fill level saturates at PLEN-1, so equality means "enough history".
  assign w_fill_ok = (r_fill == FILL_W'(PLEN - 1));

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic, word-accept strobe and the Mealy match output.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_match  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_SHIFT;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_match = w_fill_ok && (w_window == PATTERN);
        if (r_bit_idx == {IDX_W{1'b0}}) begin
          w_next = ST_REPORT;
        end else begin
          w_next = ST_SHIFT;
        end
      end
      ST_REPORT: begin
        if (out_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_REPORT;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Handshake and status flags. They are registered from the next state, so each
  // flag always agrees with the state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == ST_IDLE);
      r_out_valid <= (w_next == ST_REPORT);
      r_busy      <= (w_next != ST_IDLE);
    end
  end

  // Word capture, bit sequencing, history window and the match counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_word    <= {WIDTH{1'b0}};
      r_bit_idx <= {IDX_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_hist    <= {(PLEN-1){1'b0}};
      r_fill    <= {FILL_W{1'b0}};
    end else if (w_accept) begin
      r_word    <= in_data;
      r_bit_idx <= IDX_W'(WIDTH - 1);
      r_cnt     <= {CNT_W{1'b0}};
`ifdef PSC_CARRY_STATE_EN
      r_hist    <= r_hist;
      r_fill    <= r_fill;
`else
      r_hist    <= {(PLEN-1){1'b0}};
      r_fill    <= {FILL_W{1'b0}};
`endif
    end else if (r_state == ST_SHIFT) begin
      r_word    <= r_word;
      // Decrement wraps on the final bit. This is harmless because the next word reloads it.
      r_bit_idx <= r_bit_idx - IDX_W'(1);
      r_cnt     <= r_cnt + CNT_W'(w_match);
      r_hist    <= w_window[PLEN-2:0];
      if (w_fill_ok) begin
        r_fill  <= r_fill;
      end else begin
        r_fill  <= r_fill + FILL_W'(1);
      end
    end else begin
      r_word    <= r_word;
      r_bit_idx <= r_bit_idx;
      r_cnt     <= r_cnt;
      r_hist    <= r_hist;
      r_fill    <= r_fill;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_count = r_cnt;
  assign match     = w_match;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl
//   Directed bench for pattern_scan_ctrl with WIDTH=8, PLEN=4 and PATTERN=4'b0110.
//   Expected match masks and counts are hand-computed. In a mask, bit i stands for
//   scan bit i+1, the (i+1)-th bit sent MSB-first. Honours PSC_CARRY_STATE_EN for the
//   word-boundary case.
module tb_pattern_scan_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             Clk;
  logic             Rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             match;
  logic             busy;

  int total;
  int passed;
  int cyc;
  int hs_prev;
  int hs_last;

  pattern_scan_ctrl #(
    .WIDTH  (8),
    .PLEN   (4),
    .PATTERN(4'b0110)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .match    (match),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Free-running cycle counter.
  always @(posedge Clk) cyc <= cyc + 1;

  // Record the cycle number of each input handshake. It is sampled mid-cycle, away from the edge.
  always @(negedge Clk) begin
    if (Rst && in_valid && in_ready) begin
      hs_prev <= hs_last;
      hs_last <= cyc;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Present a word in IDLE and take it on the next edge.
  task automatic accept(input string tag, input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy_shift"}, 32'(busy), 32'd1);
  endtask

  // Walk the 8 scan cycles, checking match per bit and out_valid timing.
  task automatic scan(input string tag, input logic [7:0] mask, input int exp_cnt);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_match"}, 32'(match), 32'(mask[i]));
      chk({tag, "_out_valid_early"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_out_count"}, 32'(out_count), 32'(exp_cnt));
    chk({tag, "_in_ready_report"}, 32'(in_ready), 32'd0);
    chk({tag, "_match_report"}, 32'(match), 32'd0);
  endtask

  // Complete the output handshake and confirm the return to IDLE.
  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] carry_mask;
  int         carry_cnt;

  initial begin
    total     = 0;
    passed    = 0;
    cyc       = 0;
    hs_prev   = 0;
    hs_last   = 0;
    Rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset values.
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    Rst = 1'b1;
    tick();

    // 1. 0110_0110: matches complete on scan bits 4 and 8.
    out_ready = 1'b1;
    accept("t1", 8'b0110_0110);
    out_ready = 1'b1;
    scan("t1", 8'b1000_1000, 2);
    finish_out("t1");

    // 2. Overlap and degenerate words.
    accept("t2a", 8'b0110_1100);
    scan("t2a", 8'b0100_1000, 2);
    finish_out("t2a");
    accept("t2b", 8'hFF);
    scan("t2b", 8'h00, 0);
    finish_out("t2b");
    accept("t2c", 8'h00);
    scan("t2c", 8'h00, 0);
    finish_out("t2c");

    // 4. Word boundary: 0000_0011 then 0100_0000.
`ifdef PSC_CARRY_STATE_EN
    carry_mask = 8'b0000_0001;
    carry_cnt  = 1;
`else
    carry_mask = 8'b0000_0000;
    carry_cnt  = 0;
`endif
    accept("t4a", 8'b0000_0011);
    scan("t4a", 8'h00, 0);
    finish_out("t4a");
    accept("t4b", 8'b0100_0000);
    scan("t4b", carry_mask, carry_cnt);
    finish_out("t4b");

    // 3. Backpressure in REPORT with a pending input word held on in_valid.
    accept("t3", 8'b0110_1100);
    scan("t3", 8'b0100_1000, 2);
    in_data  = 8'b0110_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_out_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_out_count", 32'(out_count), 32'd2);
      chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_after_out_valid", 32'(out_valid), 32'd0);
    chk("t3_after_busy", 32'(busy), 32'd0);
    chk("t3_after_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_pending_taken", 32'(busy), 32'd1);
    scan("t3b", 8'b0000_1000, 1);
    finish_out("t3b");

    // 5. Reset part-way through a word, just as bit 4 completes a match.
    accept("t5", 8'b0110_0110);
    tick();
    tick();
    tick();
    chk("t5_match_pre_reset", 32'(match), 32'd1);
    Rst = 1'b0;
    #1;
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_out_count", 32'(out_count), 32'd0);
    chk("t5_rst_match", 32'(match), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    Rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_no_result", 32'(out_valid), 32'd0);
    end
    accept("t5b", 8'b0110_0000);
    scan("t5b", 8'b0000_1000, 1);
    finish_out("t5b");

    // 6. Back-to-back words with in_valid held high and out_ready high.
    out_ready = 1'b1;
    in_data   = 8'b0110_0110;
    in_valid  = 1'b1;
    tick();
    in_data = 8'b0110_1100;
    chk("t6_a_taken", 32'(busy), 32'd1);
    scan("t6a", 8'b1000_1000, 2);
    tick();
    chk("t6_idle_out_valid", 32'(out_valid), 32'd0);
    chk("t6_idle_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t6_b_taken", 32'(busy), 32'd1);
    chk("t6_spacing", 32'(hs_last - hs_prev), 32'd10);
    scan("t6b", 8'b0100_1000, 2);
    finish_out("t6b");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
